imem_dmem_arbiter: RTL and testbench

Single-port memory arbiter sharing one synchronous SRAM between the instruction-fetch port and the data-bus port of the core. It accepts one outstanding request per port, selects a winner, sequences the access onto the memory and returns a one-cycle ack with read data. It sits between the fetch/data-bus front ends and the unified memory macro.

---
 rtl/imem_dmem_arbiter_pkg.sv | 30 +++
 rtl/imem_dmem_arbiter_if.sv | 42 ++++
 rtl/imem_dmem_arbiter_pick.sv | 56 +++++
 rtl/imem_dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pcore_mem_arb_pkg
// Shared types for the instruction/data memory arbiter:
//   type_mem_arb_state_e : access sequencer states (IDLE, ACCESS, RESP)
//   type_mem_arb_gnt_e   : which requester owns the current access
//   excl_mask()          : converts a grant into the exclude mask consumed by
//                          mem_arb_pick (bit 0 = fetch port, bit 1 = data port)
// ---------------------------------------------------------------------------
package pcore_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } type_mem_arb_state_e;

  typedef enum logic {
    GNT_IF   = 1'b0,
    GNT_DBUS = 1'b1
  } type_mem_arb_gnt_e;

  localparam logic [1:0] EXCL_NONE = 2'b00;
  localparam logic [1:0] EXCL_IF   = 2'b01;
  localparam logic [1:0] EXCL_DBUS = 2'b10;

  function automatic logic [1:0] excl_mask(input type_mem_arb_gnt_e gnt);
    return (gnt == GNT_IF) ? EXCL_IF : EXCL_DBUS;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter_if
// Bus between the arbiter and the unified synchronous SRAM macro.
//   req   : access strobe, high for exactly one cycle per access
//   addr  : registered byte address
//   we    : registered write enable (0 for fetches)
//   be    : registered byte enables (all-ones for reads)
//   wdata : registered write data
//   rdata : read data, valid the cycle after req
// Modports: master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req,
    output addr,
    output we,
    output be,
    output wdata,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    input  we,
    input  be,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/imem_dmem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data ports.
// Ports:
//   if_req_i   : fetch request
//   dbus_req_i : effective data request (already qualified by dbus_sel)
//   lst_i      : port granted most recently
//   excl_i     : ports to ignore this cycle (bit 0 fetch, bit 1 data)
//   valid_o    : some non-excluded port is requesting
//   gnt_o      : winning port, meaningful only when valid_o is high
// Configuration macro: IMEM_DMEM_ARB_DBUS_PRIO_EN
//   defined   -> ties always go to the data port
//   undefined -> ties go to the port that was not granted last
// ---------------------------------------------------------------------------
module mem_arb_pick
  import pcore_mem_arb_pkg::*;
(
  input  logic              if_req_i,
  input  logic              dbus_req_i,
  input  type_mem_arb_gnt_e lst_i,
  input  logic [1:0]        excl_i,
  output logic              valid_o,
  output type_mem_arb_gnt_e gnt_o
);

  logic if_ok;
  logic dbus_ok;

  assign if_ok   = if_req_i   & ~excl_i[0];
  assign dbus_ok = dbus_req_i & ~excl_i[1];
  assign valid_o = if_ok | dbus_ok;

`ifdef IMEM_DMEM_ARB_DBUS_PRIO_EN
  // Strict data priority: the last-grant history plays no part in the choice.
  logic unused_lst;
  assign unused_lst = (lst_i == GNT_IF);

  always_comb begin
    gnt_o = GNT_IF;
    if (dbus_ok) begin
      gnt_o = GNT_DBUS;
    end
  end
`else
  // Round-robin: on a tie the port that did not win last time goes first.
  always_comb begin
    gnt_o = GNT_IF;
    if (if_ok && dbus_ok) begin
      gnt_o = (lst_i == GNT_IF) ? GNT_DBUS : GNT_IF;
    end else if (dbus_ok) begin
      gnt_o = GNT_DBUS;
    end
  end
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
// Shares one synchronous SRAM between the instruction-fetch port and the
// data-bus port. One outstanding request per port; each access takes an
// ACCESS cycle (memory strobe) followed by a RESP cycle (one-cycle ack).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   if_req_i/if_addr_i : fetch request and byte address
//   if_ack_o/if_rdata_o: fetch completion pulse and read data
//   dbus_req_i/sel_i   : data request, counted only when sel_i is high
//   dbus_addr_i/we_i/be_i/wdata_i : data access fields
//   dbus_ack_o/rdata_o : data completion pulse and read data (0 on writes)
//   mem                : master side of the SRAM bus (imem_dmem_arbiter_if)
// Configuration macro: IMEM_DMEM_ARB_DBUS_PRIO_EN (strict data priority on
// ties; round-robin when undefined), applied inside mem_arb_pick.
// ---------------------------------------------------------------------------
module imem_dmem_arbiter
  import pcore_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dbus_req_i,
  input  logic                dbus_sel_i,
  input  logic [ADDR_W-1:0]   dbus_addr_i,
  input  logic                dbus_we_i,
  input  logic [DATA_W/8-1:0] dbus_be_i,
  input  logic [DATA_W-1:0]   dbus_wdata_i,
  output logic                dbus_ack_o,
  output logic [DATA_W-1:0]   dbus_rdata_o,
  imem_dmem_arbiter_if.master mem
);

  type_mem_arb_state_e state_q, state_d;
  type_mem_arb_gnt_e   gnt_q, gnt_d;
  type_mem_arb_gnt_e   lst_q, lst_d;
  type_mem_arb_gnt_e   pick_gnt;
  logic                pick_valid;
  logic [1:0]          excl;
  logic                dbus_req_eff;

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  assign dbus_req_eff = dbus_req_i & dbus_sel_i;

  // While responding, the port being acked is ignored so the other port can
  // be chained in back-to-back; in IDLE both ports compete.
  assign excl = (state_q == RESP) ? excl_mask(gnt_q) : EXCL_NONE;

  mem_arb_pick u_pick (
    .if_req_i   (if_req_i),
    .dbus_req_i (dbus_req_eff),
    .lst_i      (lst_q),
    .excl_i     (excl),
    .valid_o    (pick_valid),
    .gnt_o      (pick_gnt)
  );

  // Next-state logic: a new winner may be loaded from IDLE or straight out
  // of RESP; its fields are captured into the mem_* registers at that point.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lst_d       = lst_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    if (state_q == RESP) begin
      lst_d = gnt_q;
    end

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (pick_valid) begin
          state_d = ACCESS;
          gnt_d   = pick_gnt;
          if (pick_gnt == GNT_IF) begin
            mem_addr_d  = if_addr_i;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_wdata_d = '0;
          end else begin
            mem_addr_d  = dbus_addr_i;
            mem_we_d    = dbus_we_i;
            mem_be_d    = dbus_we_i ? dbus_be_i : '1;
            mem_wdata_d = dbus_wdata_i;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ack/read-data steering: only the granted port sees anything, and a reset
  // arriving during RESP suppresses the ack of the abandoned access.
  always_comb begin
    if_ack_o     = 1'b0;
    dbus_ack_o   = 1'b0;
    if_rdata_o   = '0;
    dbus_rdata_o = '0;
    if ((state_q == RESP) && !rst) begin
      if (gnt_q == GNT_IF) begin
        if_ack_o   = 1'b1;
        if_rdata_o = mem.rdata;
      end else begin
        dbus_ack_o   = 1'b1;
        dbus_rdata_o = mem_we_q ? '0 : mem.rdata;
      end
    end
  end

  // State and memory-bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      lst_q       <= GNT_IF;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lst_q       <= lst_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem.req   = (state_q == ACCESS);
  assign mem.addr  = mem_addr_q;
  assign mem.we    = mem_we_q;
  assign mem.be    = mem_be_q;
  assign mem.wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_arbiter
// Directed bench for imem_dmem_arbiter: a table of single-transaction
// vectors plus hand-written sequences for ties, round-robin, the ignored
// unselected data request and reset during an access. A small byte-enabled
// SRAM model sits on the slave side of the memory interface.
// ---------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifAck;
  logic [31:0] ifRdata;
  logic        dReq;
  logic        dSel;
  logic [31:0] dAddr;
  logic        dWe;
  logic [3:0]  dBe;
  logic [31:0] dWdata;
  logic        dAck;
  logic [31:0] dRdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) memIf ();

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (ifReq),
    .if_addr_i    (ifAddr),
    .if_ack_o     (ifAck),
    .if_rdata_o   (ifRdata),
    .dbus_req_i   (dReq),
    .dbus_sel_i   (dSel),
    .dbus_addr_i  (dAddr),
    .dbus_we_i    (dWe),
    .dbus_be_i    (dBe),
    .dbus_wdata_i (dWdata),
    .dbus_ack_o   (dAck),
    .dbus_rdata_o (dRdata),
    .mem          (memIf)
  );

  // SRAM model: word store indexed by address bits [7:2], read data
  // registered one cycle after the strobe, writes honour byte enables.
  logic [31:0] store [0:63];
  logic [31:0] rdReg = 32'h0;

  assign memIf.rdata = rdReg;

  initial begin
    for (int w = 0; w < 64; w++) begin
      store[w] = 32'hC0DE_0000 | w;
    end
  end

  always @(posedge clk) begin
    if (memIf.req) begin
      if (memIf.we) begin
        for (int b = 0; b < 4; b++) begin
          if (memIf.be[b]) store[memIf.addr[7:2]][8*b +: 8] <= memIf.wdata[8*b +: 8];
        end
      end else begin
        rdReg <= store[memIf.addr[7:2]];
      end
    end
  end

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dSel;
    logic [31:0] dAddr;
    logic        dWe;
    logic [3:0]  dBe;
    logic [31:0] dWdata;
    logic        expAccess;
    logic [31:0] expAddr;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expIfAck;
    logic        expDAck;
    logic [31:0] expRdata;
  } vecT;

  vecT vecs [7];

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    ifReq  = 1'b0;
    ifAddr = 32'h0;
    dReq   = 1'b0;
    dSel   = 1'b0;
    dAddr  = 32'h0;
    dWe    = 1'b0;
    dBe    = 4'h0;
    dWdata = 32'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one vector from IDLE, check the ACCESS cycle then the RESP cycle.
  task automatic applyStimulus(input vecT v, input int i);
    @(negedge clk);
    ifReq  = v.ifReq;
    ifAddr = v.ifAddr;
    dReq   = v.dReq;
    dSel   = v.dSel;
    dAddr  = v.dAddr;
    dWe    = v.dWe;
    dBe    = v.dBe;
    dWdata = v.dWdata;
    @(negedge clk);
    checkOutput($sformatf("v%0d.memReq", i), {31'h0, memIf.req}, {31'h0, v.expAccess});
    checkOutput($sformatf("v%0d.earlyAck", i), {30'h0, ifAck, dAck}, 32'h0);
    if (v.expAccess) begin
      checkOutput($sformatf("v%0d.memAddr", i), memIf.addr, v.expAddr);
      checkOutput($sformatf("v%0d.memWe", i), {31'h0, memIf.we}, {31'h0, v.expWe});
      checkOutput($sformatf("v%0d.memBe", i), {28'h0, memIf.be}, {28'h0, v.expBe});
      if (v.expWe) checkOutput($sformatf("v%0d.memWdata", i), memIf.wdata, v.expWdata);
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d.ifAck", i), {31'h0, ifAck}, {31'h0, v.expIfAck});
    checkOutput($sformatf("v%0d.dAck", i), {31'h0, dAck}, {31'h0, v.expDAck});
    checkOutput($sformatf("v%0d.ifRdata", i), ifRdata, v.expIfAck ? v.expRdata : 32'h0);
    checkOutput($sformatf("v%0d.dRdata", i), dRdata, v.expDAck ? v.expRdata : 32'h0);
    checkOutput($sformatf("v%0d.memReqResp", i), {31'h0, memIf.req}, 32'h0);
    idleInputs();
    @(negedge clk);
  endtask

  initial begin
    // Fields: ifReq ifAddr dReq dSel dAddr dWe dBe dWdata |
    //         expAccess expAddr expWe expBe expWdata expIfAck expDAck expRdata
    vecs[0] = '{1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 1'b0, 4'h0, 32'h0,
                1'b1, 32'h04, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hC0DE_0001};
    vecs[1] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b1, 4'hF, 32'hAA,
                1'b1, 32'h08, 1'b1, 4'hF, 32'hAA, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b0, 4'h0, 32'h0,
                1'b1, 32'h08, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hAA};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b1, 4'h3, 32'h1234_5678,
                1'b1, 32'h0C, 1'b1, 4'h3, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b0, 4'h0, 32'h0,
                1'b1, 32'h0C, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hC0DE_5678};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 32'h0,
                1'b0, 32'h00, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h08, 1'b0, 1'b0, 32'h00, 1'b0, 4'h0, 32'h0,
                1'b1, 32'h08, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hAA};

    rst = 1'b1;
    idleInputs();
    doReset();

    // Reset state of every output.
    checkOutput("rst.memReq", {31'h0, memIf.req}, 32'h0);
    checkOutput("rst.memAddr", memIf.addr, 32'h0);
    checkOutput("rst.memWe", {31'h0, memIf.we}, 32'h0);
    checkOutput("rst.memBe", {28'h0, memIf.be}, 32'h0);
    checkOutput("rst.memWdata", memIf.wdata, 32'h0);
    checkOutput("rst.acks", {30'h0, ifAck, dAck}, 32'h0);
    checkOutput("rst.ifRdata", ifRdata, 32'h0);
    checkOutput("rst.dRdata", dRdata, 32'h0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Unselected data request is never served.
    $display("[TB] unselected data request");
    @(negedge clk);
    dReq  = 1'b1;
    dSel  = 1'b0;
    dAddr = 32'h14;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("nosel.memReq%0d", c), {31'h0, memIf.req}, 32'h0);
      checkOutput($sformatf("nosel.dAck%0d", c), {31'h0, dAck}, 32'h0);
    end
    idleInputs();

    // Tie straight after reset: data first, fetch chained back-to-back.
    $display("[TB] tie after reset");
    doReset();
    ifReq  = 1'b1;
    ifAddr = 32'h08;
    dReq   = 1'b1;
    dSel   = 1'b1;
    dAddr  = 32'h18;
    dWe    = 1'b1;
    dBe    = 4'hF;
    dWdata = 32'hBB;
    @(negedge clk);
    checkOutput("tie.memAddr1", memIf.addr, 32'h18);
    checkOutput("tie.memWe1", {31'h0, memIf.we}, 32'h1);
    checkOutput("tie.memWdata1", memIf.wdata, 32'hBB);
    @(negedge clk);
    checkOutput("tie.dAck", {31'h0, dAck}, 32'h1);
    checkOutput("tie.ifAckEarly", {31'h0, ifAck}, 32'h0);
    checkOutput("tie.dRdata", dRdata, 32'h0);
    dReq = 1'b0;
    @(negedge clk);
    checkOutput("tie.memReq2", {31'h0, memIf.req}, 32'h1);
    checkOutput("tie.memAddr2", memIf.addr, 32'h08);
    checkOutput("tie.memWe2", {31'h0, memIf.we}, 32'h0);
    @(negedge clk);
    checkOutput("tie.ifAck", {31'h0, ifAck}, 32'h1);
    checkOutput("tie.dAck2", {31'h0, dAck}, 32'h0);
    checkOutput("tie.ifRdata", ifRdata, 32'hAA);
    idleInputs();
    @(negedge clk);

    // Continuous contention: acks alternate data, fetch, data, fetch ...
    $display("[TB] round-robin contention");
    ifReq  = 1'b1;
    ifAddr = 32'h08;
    dReq   = 1'b1;
    dSel   = 1'b1;
    dAddr  = 32'h18;
    dWe    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d.memReq", k), {31'h0, memIf.req}, 32'h1);
      @(negedge clk);
      if (k % 2 == 0) begin
        checkOutput($sformatf("rr%0d.acks", k), {30'h0, ifAck, dAck}, 32'h1);
        checkOutput($sformatf("rr%0d.dRdata", k), dRdata, 32'hBB);
      end else begin
        checkOutput($sformatf("rr%0d.acks", k), {30'h0, ifAck, dAck}, 32'h2);
        checkOutput($sformatf("rr%0d.ifRdata", k), ifRdata, 32'hAA);
      end
    end
    idleInputs();
    @(negedge clk);

    // Reset during ACCESS abandons the access; a fresh fetch then completes.
    $display("[TB] reset during access");
    ifReq  = 1'b1;
    ifAddr = 32'h10;
    @(negedge clk);
    checkOutput("abort.memReq", {31'h0, memIf.req}, 32'h1);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort.memReqAfter", {31'h0, memIf.req}, 32'h0);
    checkOutput("abort.memAddr", memIf.addr, 32'h0);
    checkOutput("abort.memBe", {28'h0, memIf.be}, 32'h0);
    checkOutput("abort.acks", {30'h0, ifAck, dAck}, 32'h0);
    checkOutput("abort.ifRdata", ifRdata, 32'h0);
    @(negedge clk);
    checkOutput("abort.acksLater", {30'h0, ifAck, dAck}, 32'h0);
    ifReq  = 1'b1;
    ifAddr = 32'h04;
    @(negedge clk);
    checkOutput("post.memAddr", memIf.addr, 32'h04);
    @(negedge clk);
    checkOutput("post.ifAck", {31'h0, ifAck}, 32'h1);
    checkOutput("post.ifRdata", ifRdata, 32'hC0DE_0001);
    idleInputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
